// File: rtl/adxl_spi_pkg.sv
// adxl_spi_pkg: register map, reset values and FSM state codes for adxl_spi_responder.
package adxl_spi_pkg;
    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
    localparam logic [7:0] BW_RATE_RST      = 8'h0A;
    localparam logic [7:0] POWER_CTL_RST    = 8'h00;
    localparam logic [7:0] DATA_FORMAT_RST  = 8'h00;
    localparam logic [2:0] ST_WAIT_IDLE     = 3'd0;
    localparam logic [2:0] ST_IDLE          = 3'd1;
    localparam logic [2:0] ST_CMD           = 3'd2;
    localparam logic [2:0] ST_WDATA         = 3'd3;
    localparam logic [2:0] ST_RDATA         = 3'd4;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizes SPI pins into clk and emits registered SCLK/CS_N edge pulses.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_n,
    output logic mosi
);
    logic [STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic sclk_d, cs_d;
    // CS_N chain resets low so a transaction already in flight never looks like a fresh falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= '1;
            cs_q      <= '0;
            mosi_q    <= '0;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
            cs_n      <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            sclk_q    <= (sclk_q << 1) | STAGES'(spi_sclk);
            cs_q      <= (cs_q << 1) | STAGES'(spi_cs_n);
            mosi_q    <= (mosi_q << 1) | STAGES'(spi_mosi);
            sclk_d    <= sclk_q[STAGES-1];
            cs_d      <= cs_q[STAGES-1];
            sclk_rise <= sclk_q[STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_q[STAGES-1] & sclk_d;
            cs_rise   <= cs_q[STAGES-1] & ~cs_d;
            cs_fall   <= ~cs_q[STAGES-1] & cs_d;
            cs_n      <= cs_q[STAGES-1];
            mosi      <= mosi_q[STAGES-1];
        end
    end
endmodule

// File: rtl/adxl_spi_responder.sv
// adxl_spi_responder: mode-3 SPI accelerometer emulator; define ADXL_RESP_INT_SOURCE_EN for INT_SOURCE/data_ready.
module adxl_spi_responder
    import adxl_spi_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [7:0]  reg_bw_rate,
    output logic [7:0]  reg_power_ctl,
    output logic [7:0]  reg_data_format,
`ifdef ADXL_RESP_INT_SOURCE_EN
    output logic        data_ready,
`endif
    output logic        xfer_done
);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n, mosi;
    logic [2:0] state, bit_cnt;
    logic [6:0] shift;
    logic [7:0] shifted, rd_shift, rd_val, rd_next, int_source;
    logic [5:0] addr;
    logic mb, got_byte, byte_done;
    logic [47:0] staging, shadow;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_rise(cs_rise), .cs_fall(cs_fall),
        .cs_n(cs_n), .mosi(mosi)
    );

    assign shifted   = {shift, mosi};
    assign byte_done = sclk_rise && bit_cnt == 3'd7;
    assign rd_next   = bit_cnt == 3'd0 ? rd_val : rd_shift;

`ifdef ADXL_RESP_INT_SOURCE_EN
    // a new sample wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) data_ready <= 1'b0;
        else if (sample_valid) data_ready <= 1'b1;
        else if (state == ST_RDATA && byte_done && addr == ADDR_DATAZ1) data_ready <= 1'b0;
    end
    assign int_source = {data_ready, 7'b0};
`else
    assign int_source = 8'h00;
`endif

    always_comb begin
        case (addr)
            ADDR_DEVID:       rd_val = DEVID;
            ADDR_BW_RATE:     rd_val = reg_bw_rate;
            ADDR_POWER_CTL:   rd_val = reg_power_ctl;
            ADDR_INT_SOURCE:  rd_val = int_source;
            ADDR_DATA_FORMAT: rd_val = reg_data_format;
            ADDR_DATAX0:      rd_val = shadow[7:0];
            ADDR_DATAX1:      rd_val = shadow[15:8];
            ADDR_DATAY0:      rd_val = shadow[23:16];
            ADDR_DATAY1:      rd_val = shadow[31:24];
            ADDR_DATAZ0:      rd_val = shadow[39:32];
            ADDR_DATAZ1:      rd_val = shadow[47:40];
            default:          rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_WAIT_IDLE;
            bit_cnt         <= 3'd0;
            shift           <= 7'd0;
            rd_shift        <= 8'd0;
            addr            <= 6'd0;
            mb              <= 1'b0;
            got_byte        <= 1'b0;
            staging         <= 48'd0;
            shadow          <= 48'd0;
            reg_bw_rate     <= BW_RATE_RST;
            reg_power_ctl   <= POWER_CTL_RST;
            reg_data_format <= DATA_FORMAT_RST;
            spi_miso        <= 1'b0;
            spi_miso_oe     <= 1'b0;
            xfer_done       <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            if (sample_valid) staging <= {sample_z, sample_y, sample_x};
            if (state inside {ST_CMD, ST_WDATA, ST_RDATA} && cs_rise) begin
                state       <= ST_IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                xfer_done   <= got_byte;
            end else begin
                case (state)
                    ST_WAIT_IDLE: if (cs_n) state <= ST_IDLE;
                    ST_IDLE: if (cs_fall) begin
                        state    <= ST_CMD;
                        bit_cnt  <= 3'd0;
                        got_byte <= 1'b0;
                        shadow   <= staging;
                    end
                    ST_CMD: if (sclk_rise) begin
                        shift   <= shifted[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            got_byte <= 1'b1;
                            mb       <= shifted[6];
                            addr     <= shifted[5:0];
                            state    <= shifted[7] ? ST_RDATA : ST_WDATA;
                        end
                    end
                    ST_WDATA: if (sclk_rise) begin
                        shift   <= shifted[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            reg_bw_rate     <= addr == ADDR_BW_RATE ? shifted : reg_bw_rate;
                            reg_power_ctl   <= addr == ADDR_POWER_CTL ? shifted : reg_power_ctl;
                            reg_data_format <= addr == ADDR_DATA_FORMAT ? shifted : reg_data_format;
                            addr            <= mb ? addr + 6'd1 : addr;
                        end
                    end
                    ST_RDATA: begin
                        // a byte boundary (bit_cnt 0) fetches the next register at the first falling edge
                        if (sclk_fall) begin
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= rd_next[7];
                            rd_shift    <= rd_next << 1;
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done && mb) addr <= addr + 6'd1;
                        end
                    end
                    default: state <= ST_WAIT_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adxl_spi_responder.sv
// tb_adxl_spi_responder: directed SPI master transactions against hand-computed register/sample bytes.
module tb_adxl_spi_responder;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk = 1'b1, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, sample_valid = 1'b0, xfer_done;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic [7:0] reg_bw_rate, reg_power_ctl, reg_data_format;
`ifdef ADXL_RESP_INT_SOURCE_EN
    logic data_ready;
`endif

    int n_tests = 0, n_fail = 0, done_cnt = 0;
    logic [7:0] rx [8];
    logic [7:0] rx_oe [8];
    logic [7:0] cmd_oe;

    always #5 clk = ~clk;
    always @(posedge clk) if (xfer_done) done_cnt <= done_cnt + 1;

    adxl_spi_responder dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z), .sample_valid(sample_valid),
        .reg_bw_rate(reg_bw_rate), .reg_power_ctl(reg_power_ctl), .reg_data_format(reg_data_format),
`ifdef ADXL_RESP_INT_SOURCE_EN
        .data_ready(data_ready),
`endif
        .xfer_done(xfer_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] r, output logic [7:0] oe);
        r = '0;
        oe = '0;
        for (int i = 0; i < nb; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[7-i];
            tick(HALF);
            r[7-i]  = spi_miso;
            oe[7-i] = spi_miso_oe;
            spi_sclk = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic get_byte(input int i);
        logic [7:0] r, m;
        spi_bits(8'h00, 8, r, m);
        rx[i] = r;
        rx_oe[i] = m;
    endtask

    task automatic read_burst(input logic [7:0] cmd, input int n);
        logic [7:0] r;
        cs_low();
        spi_bits(cmd, 8, r, cmd_oe);
        for (int i = 0; i < n; i++) get_byte(i);
        cs_high();
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] r, m;
        cs_low();
        spi_bits({2'b00, a}, 8, r, m);
        spi_bits(d, 8, r, m);
        cs_high();
    endtask

    task automatic load_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sample_x = x;
        sample_y = y;
        sample_z = z;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [63:0] exp);
        check({tag, "_cmd_oe"}, cmd_oe, 8'h00);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), rx[i], exp[8*i +: 8]);
            check($sformatf("%s_oe[%0d]", tag, i), rx_oe[i], 8'hFF);
        end
    endtask

    initial begin
        logic [7:0] r, m;
        int d0;
        tick(4);
        check("rst_bw_rate", reg_bw_rate, 8'h0A);
        check("rst_power_ctl", reg_power_ctl, 8'h00);
        check("rst_data_format", reg_data_format, 8'h00);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_xfer_done", xfer_done, 1'b0);
        rst = 1'b0;
        tick(8);

        d0 = done_cnt;
        read_burst(8'h80, 1);
        check_bytes("devid", 1, 64'hE5);
        check("devid_oe_after", spi_miso_oe, 1'b0);
        check("devid_miso_after", spi_miso, 1'b0);
        check("devid_done", done_cnt - d0, 1);

        write_reg(6'h31, 8'h00);
        write_reg(6'h2C, 8'h0F);
        write_reg(6'h2D, 8'h08);
        check("wr_data_format", reg_data_format, 8'h00);
        check("wr_bw_rate", reg_bw_rate, 8'h0F);
        check("wr_power_ctl", reg_power_ctl, 8'h08);
        read_burst(8'hAC, 1);
        check_bytes("rd_bw", 1, 64'h0F);

        load_sample(16'h1234, 16'hFFFE, 16'h0100);
`ifdef ADXL_RESP_INT_SOURCE_EN
        check("data_ready_set", data_ready, 1'b1);
`endif
        write_reg(6'h32, 8'hAA);
        read_burst(8'hF2, 6);
        check_bytes("xyz", 6, 64'h0100FFFE1234);
`ifdef ADXL_RESP_INT_SOURCE_EN
        check("data_ready_clr", data_ready, 1'b0);
`endif

        cs_low();
        spi_bits(8'hF2, 8, r, cmd_oe);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) load_sample(16'hA5A5, 16'h0001, 16'h8000);
            get_byte(i);
        end
        cs_high();
        check_bytes("coherent_old", 6, 64'h0100FFFE1234);
        read_burst(8'hF2, 6);
        check_bytes("coherent_new", 6, 64'h80000001A5A5);

        read_burst(8'hB2, 3);
        check_bytes("mb0", 3, 64'hA5A5A5);
        read_burst(8'hFF, 2);
        check_bytes("wrap", 2, 64'hE500);
        read_burst(8'hB0, 1);
        check_bytes("int_src", 1, 64'h00);

        d0 = done_cnt;
        cs_low();
        spi_bits(8'h2D, 8, r, m);
        spi_bits(8'hFF, 4, r, m);
        cs_high();
        check("partial_power_ctl", reg_power_ctl, 8'h08);
        check("partial_done", done_cnt - d0, 1);
        read_burst(8'hAD, 1);
        check_bytes("partial_rd", 1, 64'h08);

        cs_low();
        spi_bits(8'h80, 8, r, m);
        spi_bits(8'h00, 3, r, m);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_mid_miso", spi_miso, 1'b0);
        check("rst_mid_oe", spi_miso_oe, 1'b0);
        check("rst_mid_bw", reg_bw_rate, 8'h0A);
        spi_bits(8'hFF, 5, r, m);
        check("rst_mid_rest_oe", m, 8'h00);
        cs_high();
        read_burst(8'h80, 1);
        check_bytes("post_rst_devid", 1, 64'hE5);
        read_burst(8'hAD, 1);
        check_bytes("post_rst_power", 1, 64'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
